// File: rtl/adc_sensor_reader_pkg.sv
// Shared types and default frame geometry for the serial-ADC sensor reader.
package adc_pkg;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_BITS  = 4;
    localparam int DATA_W     = FRAME_BITS - LEAD_BITS;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        QUIET
    } state_t;

    // Width of a counter that must hold the value n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adc_sensor_reader_if.sv
// Sensor request/received handshake between the trainer and the ADC reader.
interface adc_sensor_reader_if #(
    parameter int DATA_W = adc_pkg::DATA_W
);
    logic              sensor_request;
    logic              sensor_received;
    logic              busy;
    logic [DATA_W-1:0] adc_data;
    logic              frame_err;

    modport master (
        output sensor_request,
        input  sensor_received,
        input  busy,
        input  adc_data,
        input  frame_err
    );

    modport slave (
        input  sensor_request,
        output sensor_received,
        output busy,
        output adc_data,
        output frame_err
    );
endinterface

// File: rtl/adc_sensor_reader_sclk_gen.sv
// Half-period divider: ticks every CLK_DIV cycles while run is high and
// toggles the registered SCLK on those ticks while sclk_en is high.
module adc_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic sclk_en,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sclk
);
    localparam int DIV_W = adc_pkg::cnt_w(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;

    assign tick = run && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise = tick && sclk_en && !sclk;
    assign fall = tick && sclk_en && sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else begin
            // Restart on terminal count or when idle, so every phase starts at 0.
            if (!run || tick) div_cnt <= '0;
            else              div_cnt <= div_cnt + 1'b1;

            if (!sclk_en)  sclk <= 1'b0;
            else if (tick) sclk <= !sclk;
        end
    end
endmodule

// File: rtl/adc_sensor_reader.sv
// Responder side of the sensor handshake: runs one SPI-style frame on an
// external serial ADC per request and returns the sample with a 1-cycle ack.
module adc_sensor_reader #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = adc_pkg::FRAME_BITS,
    parameter int LEAD_BITS  = adc_pkg::LEAD_BITS
) (
    input  logic               clock,
    input  logic               reset,
    adc_sensor_reader_if.slave sif,
    output logic               adc_cs_n,
    output logic               adc_sclk,
    input  logic               adc_miso
);
    import adc_pkg::*;

    localparam int DW    = FRAME_BITS - LEAD_BITS;
    localparam int BIT_W = cnt_w(FRAME_BITS);

    state_t                state;
    logic [BIT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  miso_q;
    logic                  run;
    logic                  sclk_en;
    logic                  tick;
    logic                  rise;
    logic                  fall;

    // The divider also times SETUP and QUIET; SCLK only toggles in SHIFT.
    assign run     = (state == SETUP) || (state == SHIFT) || (state == QUIET);
    assign sclk_en = (state == SHIFT);

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk     (clock),
        .rst     (reset),
        .run     (run),
        .sclk_en (sclk_en),
        .tick    (tick),
        .rise    (rise),
        .fall    (fall),
        .sclk    (adc_sclk)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            bit_cnt             <= '0;
            shreg               <= '0;
            miso_q              <= 1'b0;
            adc_cs_n            <= 1'b1;
            sif.busy            <= 1'b0;
            sif.sensor_received <= 1'b0;
            sif.adc_data        <= '0;
            sif.frame_err       <= 1'b0;
        end else begin
            // miso_q and the shift-register LSB form the two synchroniser
            // stages, so a bit driven after SCLK falls lands at the next rise.
            miso_q              <= adc_miso;
            sif.sensor_received <= 1'b0;
            case (state)
                IDLE: begin
                    if (sif.sensor_request) begin
                        state    <= SETUP;
                        adc_cs_n <= 1'b0;
                        sif.busy <= 1'b1;
                        bit_cnt  <= '0;
                    end
                end
                SETUP: begin
                    if (tick) state <= SHIFT;
                end
                SHIFT: begin
                    if (rise) begin
                        shreg   <= {shreg[FRAME_BITS-2:0], miso_q};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (fall && bit_cnt == BIT_W'(FRAME_BITS)) begin
                        state    <= DONE;
                        adc_cs_n <= 1'b1;
                    end
                end
                DONE: begin
                    sif.sensor_received <= 1'b1;
                    sif.adc_data        <= shreg[DW-1:0];
                    sif.frame_err       <= |shreg[FRAME_BITS-1 -: LEAD_BITS];
                    state               <= QUIET;
                end
                QUIET: begin
                    if (tick) begin
                        state    <= IDLE;
                        sif.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_sensor_reader.sv
// Randomized bench: two readers (CLK_DIV=2 with an async-style ADC model that
// shifts on SCLK fall, CLK_DIV=1 with a synchronous model that shifts on rise).
module tb_adc_sensor_reader;
    localparam int FB = 16;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic cs_a, sclk_a, miso_a;
    logic cs_b, sclk_b, miso_b;
    logic [15:0] word_a, word_b;
    int idx_a, idx_b;
    int cyc = 0, rises_a = 0, rises_b = 0, acks_a = 0;
    int n_chk = 0, n_err = 0;

    adc_sensor_reader_if ifa ();
    adc_sensor_reader_if ifb ();

    adc_sensor_reader #(.CLK_DIV(2)) dut_a (
        .clock(clk), .reset(rst_a), .sif(ifa),
        .adc_cs_n(cs_a), .adc_sclk(sclk_a), .adc_miso(miso_a)
    );
    adc_sensor_reader #(.CLK_DIV(1)) dut_b (
        .clock(clk), .reset(rst_b), .sif(ifb),
        .adc_cs_n(cs_b), .adc_sclk(sclk_b), .adc_miso(miso_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge sclk_a) rises_a <= rises_a + 1;
    always @(posedge sclk_b) rises_b <= rises_b + 1;
    always @(negedge clk) if (ifa.sensor_received) acks_a <= acks_a + 1;

    // ADC models: MSB first, bit 0 presented while CS is low before any clock.
    always @(negedge sclk_a or posedge cs_a)
        if (cs_a) idx_a = 0; else idx_a = idx_a + 1;
    always @(posedge sclk_b or posedge cs_b)
        if (cs_b) idx_b = 0; else idx_b = idx_b + 1;
    always_comb begin
        miso_a = 1'b0;
        miso_b = 1'b0;
        if (idx_a < FB) miso_a = word_a[4'(FB - 1 - idx_a)];
        if (idx_b < FB) miso_b = word_b[4'(FB - 1 - idx_b)];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic recv(input int sel);
        return sel != 0 ? ifb.sensor_received : ifa.sensor_received;
    endfunction
    function automatic logic busy(input int sel);
        return sel != 0 ? ifb.busy : ifa.busy;
    endfunction
    function automatic logic [11:0] data(input int sel);
        return sel != 0 ? ifb.adc_data : ifa.adc_data;
    endfunction
    function automatic logic ferr(input int sel);
        return sel != 0 ? ifb.frame_err : ifa.frame_err;
    endfunction
    function automatic int rises(input int sel);
        return sel != 0 ? rises_b : rises_a;
    endfunction

    task automatic wait_idle(input int sel);
        int t = 0;
        while (busy(sel) && t < 300) begin @(negedge clk); t++; end
        if (busy(sel)) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    // One request; expected latency, sample and lead-bit error from the spec rules.
    task automatic frame(input int sel, input logic [15:0] w, input string tag);
        int n, t, r0, div;
        div = (sel != 0) ? 1 : 2;
        if (sel != 0) begin word_b = w; ifb.sensor_request = 1'b1; end
        else          begin word_a = w; ifa.sensor_request = 1'b1; end
        r0 = rises(sel);
        @(negedge clk);
        n = cyc;
        ifa.sensor_request = 1'b0;
        ifb.sensor_request = 1'b0;
        t = 0;
        while (!recv(sel) && t < 300) begin @(negedge clk); t++; end
        if (!recv(sel)) chk({tag, "_timeout"}, 0, 1);
        else begin
            chk({tag, "_lat"},   cyc - n, (2 * FB + 1) * div + 1);
            chk({tag, "_data"},  data(sel), w[11:0]);
            chk({tag, "_err"},   ferr(sel), |w[15:12]);
            chk({tag, "_rises"}, rises(sel) - r0, FB);
            @(negedge clk);
            chk({tag, "_pulse"}, recv(sel), 0);
            chk({tag, "_hold"},  data(sel), w[11:0]);
        end
        wait_idle(sel);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int c0, prev, nacks, run, min_run, t, a0, r0;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.sensor_request = 1'b0; ifb.sensor_request = 1'b0;
        word_a = '0; word_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_recv", ifa.sensor_received, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_data", ifa.adc_data, 0);
        chk("rst_err",  ifa.frame_err, 0);
        chk("rst_cs",   cs_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_b_cs", cs_b, 1);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (5) @(negedge clk);

        frame(0, 16'h0ABC, "abc");
        frame(0, 16'h8FFF, "lead");
        frame(0, 16'h0001, "one");
        for (int i = 0; i < 8; i++) begin
            w = 16'($urandom);
            if (i % 2 == 0) w[15:12] = 4'h0;
            frame(0, w, "rnd");
        end

        // Held request: back-to-back frames at the minimum period.
        word_a = 16'h0C3A;
        ifa.sensor_request = 1'b1;
        c0 = cyc; prev = -1; nacks = 0; run = 0; min_run = 1000;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ifa.sensor_received) begin
                if (prev >= 0) chk("hold_gap", cyc - prev, (2 * FB + 2) * 2 + 2);
                chk("hold_data", ifa.adc_data, 12'hC3A);
                prev = cyc;
                nacks++;
            end
            if (cs_a) run++;
            else begin
                if (nacks > 0 && run > 0 && run < min_run) min_run = run;
                run = 0;
            end
        end
        ifa.sensor_request = 1'b0;
        chk("hold_n", nacks, (500 - ((2 * FB + 1) * 2 + 2)) / ((2 * FB + 2) * 2 + 2) + 1);
        chk("hold_csgap", min_run >= 3, 1);
        wait_idle(0);

        // Requests during SHIFT and QUIET are dropped.
        a0 = acks_a;
        word_a = 16'h0123;
        ifa.sensor_request = 1'b1;
        @(negedge clk);
        ifa.sensor_request = 1'b0;
        repeat (20) @(negedge clk);
        ifa.sensor_request = 1'b1;
        @(negedge clk);
        ifa.sensor_request = 1'b0;
        t = 0;
        while (!ifa.sensor_received && t < 300) begin @(negedge clk); t++; end
        ifa.sensor_request = 1'b1;
        @(negedge clk);
        ifa.sensor_request = 1'b0;
        repeat (150) @(negedge clk);
        chk("ign_acks", acks_a - a0, 1);
        chk("ign_busy", ifa.busy, 0);
        chk("ign_data", ifa.adc_data, 12'h123);

        // Reset mid-SHIFT after 7 SCLK rises.
        word_a = 16'h0F0F;
        a0 = acks_a;
        r0 = rises_a;
        ifa.sensor_request = 1'b1;
        @(negedge clk);
        ifa.sensor_request = 1'b0;
        t = 0;
        while (rises_a - r0 < 7 && t < 200) begin @(negedge clk); t++; end
        chk("mid_sclk_hi", sclk_a, 1);
        #1 rst_a = 1'b1;
        #1;
        chk("mid_cs",   cs_a, 1);
        chk("mid_sclk", sclk_a, 0);
        chk("mid_busy", ifa.busy, 0);
        chk("mid_data", ifa.adc_data, 0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (150) @(negedge clk);
        chk("mid_noack", acks_a - a0, 0);
        frame(0, 16'h0567, "post");

        // CLK_DIV=1 with the synchronous ADC model.
        frame(1, 16'h07FF, "d1");
        for (int i = 0; i < 3; i++) frame(1, 16'($urandom), "d1rnd");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/adc_sensor_reader.md
# adc_sensor_reader

Serial-ADC front end answering the trainer's sensor request: on a request it runs one SPI-style conversion frame on an external 12-bit ADC and returns the sample with a one-cycle acknowledge. It is the responder side of the sensor request/received handshake. Its `adc_data` output feeds the 12-bit ADC input of the volts-to-temperature path.

## Interface
- `CLK_DIV`, 4: system-clock cycles per SCLK half-period; legal range 1..255.
- `FRAME_BITS`, 16: SCLK cycles per conversion frame.
- `LEAD_BITS`, 4: leading bits per frame that must read 0.
- Data width is fixed at `FRAME_BITS - LEAD_BITS` = 12.

Ports:
- `clock` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `sensor_request` in 1: level; sampled only in IDLE.
- `sensor_received` out 1: one-cycle pulse; `adc_data` and `frame_err` are valid in this cycle.
- `busy` out 1: high in every state except IDLE.
- `adc_data` out 12: last sample; holds its value between frames.
- `frame_err` out 1: at least one lead bit of the last frame read 1; updated with `adc_data`.
- `adc_cs_n` out 1: ADC chip select, active low.
- `adc_sclk` out 1: ADC serial clock; idles low.
- `adc_miso` in 1: ADC serial data, MSB first; the ADC changes it after SCLK falls.

Reset values: `sensor_received` 0, `busy` 0, `adc_data` 0, `frame_err` 0, `adc_cs_n` 1, `adc_sclk` 0.

## Operation
- **FSM:** IDLE → SETUP → SHIFT → DONE → QUIET → IDLE.
- **IDLE:** `adc_cs_n`=1, `adc_sclk`=0. If `sensor_request`=1 at a clock edge, go to SETUP; `adc_cs_n` goes low in the same edge.
- **SETUP:** lasts `CLK_DIV` cycles with `adc_cs_n`=0 and `adc_sclk`=0. This is the CS-to-first-edge setup time.
- **SHIFT:** `FRAME_BITS` bit periods. Each bit period is `CLK_DIV` cycles with SCLK low, then `CLK_DIV` cycles with SCLK high.
  - `adc_miso` is captured into the shift register at the edge that drives SCLK high.
  - After the last high phase, SCLK goes low and the FSM enters DONE.
- **DONE:** one cycle.
  - `adc_cs_n`=1, `sensor_received`=1.
  - `adc_data` = low 12 bits of the shift register.
  - `frame_err` = OR of the `LEAD_BITS` MSBs.
  - `adc_data` updates even when `frame_err`=1.
- **QUIET:** `CLK_DIV` cycles with `adc_cs_n`=1, then IDLE.
- **Request rules:** `sensor_request` is ignored outside IDLE; it is not queued. A held-high request produces back-to-back frames.
- **Arithmetic:**
  - Divider counter width is ceil(log2(CLK_DIV+1)) bits.
  - Bit counter width is ceil(log2(FRAME_BITS+1)) bits.
  - Both counters compare by equality to terminal count; neither wraps.
- **Reset mid-frame:** asynchronous return to IDLE. `adc_cs_n` goes high and `adc_sclk` goes low immediately. No `sensor_received` is issued for the aborted frame, and `adc_data` clears to 0.

## Timing
- Request sampled at edge N → `sensor_received` high for exactly the cycle after edge N + (2·FRAME_BITS+1)·CLK_DIV + 1. With defaults that is edge N+133.
- Minimum request-to-request period: (2·FRAME_BITS+2)·CLK_DIV + 2 cycles.
- SCLK frequency is clock/(2·CLK_DIV). SCLK, CS and all outputs are registered, so there are no glitches.
- `adc_miso` is sampled after being held for a full SCLK-low phase. It passes through a 2-flop synchroniser; the capture point is therefore the synchronised value of the previous low phase. This fixed 2-cycle skew is required, and `CLK_DIV` ≥ 2 is required when `adc_miso` is asynchronous.

## Structure
- Package `adc_pkg`:
  - state enum (IDLE, SETUP, SHIFT, DONE, QUIET)
  - default constants `FRAME_BITS`=16, `LEAD_BITS`=4, `DATA_W`=12
- Sub-module `adc_sclk_gen`:
  - `CLK_DIV` divider with `run` input
  - outputs: `rise` tick, `fall` tick, registered `sclk`
- Top-level module: FSM, bit counter, synchroniser, shift register and output registers.

## Test plan
- CLK_DIV=2. ADC model returns 16'h0ABC; request at edge 10 → 16 SCLK rises; `sensor_received` at edge 77; `adc_data`=12'hABC; `frame_err`=0.
- ADC model returns 16'h8FFF → `adc_data`=12'hFFF, `frame_err`=1; the next frame returning 16'h0001 → `adc_data`=12'h001, `frame_err`=0.
- `sensor_request` held high for 500 cycles with CLK_DIV=2 → acks spaced exactly 70 cycles apart; `adc_cs_n` high for ≥3 cycles between frames.
- Request pulsed during SHIFT and again during QUIET → ignored; exactly one ack results.
- Reset asserted mid-SHIFT at bit 7 → `adc_cs_n`=1, `adc_sclk`=0, `busy`=0, `adc_data`=0 without a clock edge; no ack. A new request after reset completes normally.
- CLK_DIV=1 with a synchronous MISO model returning 16'h07FF → `adc_data`=12'h7FF; ack at N+34.
